// File: rtl/imem_loadable.sv
// Instruction memory with a loader port and a RUN/LOAD/DRAIN mode FSM; fetches have one cycle of read latency.
// Optional feature: define IMEM_MISALIGN_TRAP_EN to trap misaligned fetches and drop misaligned loader writes.
module imem_loadable #(
   parameter int          DEPTH  = 64,
   parameter int          ADDR_W = 32,
   parameter logic [31:0] NOOP   = 32'hFC000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic              stall,
   input  logic [ADDR_W-1:0] addr,
   output logic [31:0]       instr,
   output logic              valid,
   output logic              fault,
   input  logic              load_mode,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   output logic              ld_err
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int WIDX_W = ADDR_W - 2;
   localparam logic [WIDX_W:0] DEPTH_W = (WIDX_W + 1)'(DEPTH);

   typedef enum logic [1:0] {RUN, LOAD, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [31:0]       mem [DEPTH];
   logic [DEPTH-1:0]  written;

   logic [WIDX_W-1:0] fetch_widx, ld_widx;
   logic [IDX_W-1:0]  fetch_idx, ld_idx;
   logic              fetch_mis, ld_mis;
   logic              fetch_ok, ld_ok, ld_hs, ld_we;

   assign fetch_widx = addr[ADDR_W-1:2];
   assign ld_widx    = ld_addr[ADDR_W-1:2];
   assign fetch_idx  = fetch_widx[IDX_W-1:0];
   assign ld_idx     = ld_widx[IDX_W-1:0];

`ifdef IMEM_MISALIGN_TRAP_EN
   assign fetch_mis = |addr[1:0];
   assign ld_mis    = |ld_addr[1:0];
`else
   // Byte offset bits are don't-care when misalignment trapping is disabled.
   logic unused_lsbs;
   assign unused_lsbs = ^{addr[1:0], ld_addr[1:0]};
   assign fetch_mis   = 1'b0;
   assign ld_mis      = 1'b0;
`endif

   assign fetch_ok = ({1'b0, fetch_widx} < DEPTH_W) && !fetch_mis;
   assign ld_ok    = ({1'b0, ld_widx} < DEPTH_W) && !ld_mis;
   assign ld_hs    = ld_valid && ld_ready;
   assign ld_we    = ld_hs && ld_ok;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // NOTE: defaults first so no path through the block leaves an output unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      ld_ready = 1'b0;
      unique case (state_q)
         RUN:   if (load_mode) state_d = LOAD;
         LOAD:  begin
            ld_ready = 1'b1;
            if (!load_mode) state_d = DRAIN;
         end
         DRAIN: state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // NOTE: the array has no reset; validity is tracked by the resettable written bits instead.
   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_idx] <= ld_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         written <= '0;
         ld_err  <= 1'b0;
      end else if (ld_hs) begin
         if (ld_ok) written[ld_idx] <= 1'b1;
         else       ld_err          <= 1'b1;
      end
   end

   // Fetch outputs; stall holds them, and non-RUN modes never touch the array.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr <= NOOP;
         valid <= 1'b0;
         fault <= 1'b0;
      end else if (!stall) begin
         if (!fetch_req) begin
            instr <= NOOP;
            valid <= 1'b0;
            fault <= 1'b0;
         end else if (state_q != RUN || !fetch_ok) begin
            instr <= NOOP;
            valid <= 1'b1;
            fault <= 1'b1;
         end else begin
            instr <= written[fetch_idx] ? mem[fetch_idx] : NOOP;
            valid <= 1'b1;
            fault <= 1'b0;
         end
      end
   end

endmodule

// File: doc/imem_loadable.md
IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit instruction words (power of two, 4..1024).
REQ-002 Parameter ADDR_W, default 32, byte-address width of the fetch and load ports.
REQ-003 Parameter NOOP, default 32'hFC000000, word returned for any invalid or unwritten fetch (opcode 111111).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 fetch_req  input  1  fetch request for addr in the current cycle.
REQ-007 stall  input  1  hold instr/valid/fault unchanged; the request is ignored.
REQ-008 addr  input  ADDR_W  fetch byte address.
REQ-009 instr  output  32  fetched instruction, registered.
REQ-010 valid  output  1  instr holds the result of an accepted fetch.
REQ-011 fault  output  1  the accepted fetch was out of range, misaligned or in a blocked mode.
REQ-012 load_mode  input  1  level request to enter or stay in program-load mode.
REQ-013 ld_valid  input  1  loader word offered.
REQ-014 ld_ready  output  1  loader word accepted this cycle when ld_valid is also high.
REQ-015 ld_addr  input  ADDR_W  loader byte address.
REQ-016 ld_data  input  32  loader instruction word.
REQ-017 ld_err  output  1  sticky flag: a loader word targeted an out-of-range address.

Function
REQ-018 Word index = addr[ADDR_W-1:2]; an index >= DEPTH is out of range.
REQ-019 The storage array is not reset; each word has a written bit, and all written bits clear on reset.
REQ-020 States: RUN, LOAD and DRAIN; reset enters RUN.
REQ-021 RUN -> LOAD when load_mode=1; LOAD -> DRAIN when load_mode=0; DRAIN -> RUN unconditionally after exactly one cycle.
REQ-022 ld_ready=1 only in LOAD; a handshake (ld_valid & ld_ready) writes ld_data and sets the written bit of the target word.
REQ-023 An out-of-range loader handshake writes nothing and sets ld_err; ld_err clears only on reset.
REQ-024 In RUN with stall=0 and fetch_req=1: at the next edge valid=1 and instr=mem[index] (read latency 1 cycle).
REQ-025 An out-of-range fetch returns instr=NOOP, valid=1, fault=1.
REQ-026 A fetch of an unwritten in-range word returns instr=NOOP, valid=1, fault=0.
REQ-027 In RUN with stall=0 and fetch_req=0: at the next edge valid=0, fault=0, instr=NOOP.
REQ-028 In LOAD or DRAIN, a fetch with stall=0 returns instr=NOOP, valid=1, fault=1; no array read occurs.
REQ-029 stall=1 has priority over fetch_req and holds all three fetch outputs in every state.
REQ-030 A word loaded in LOAD is visible to the first RUN fetch after DRAIN; no bypass path exists.
REQ-031 A load_mode toggle during stall follows REQ-021; the held outputs stay unchanged.

Reset
REQ-032 Reset applies immediately and asynchronously: state=RUN, instr=NOOP, valid=0, fault=0, ld_ready=0, ld_err=0, all written bits=0.
REQ-033 Reset during LOAD discards the whole program: every word reads NOOP afterwards.

Configuration
REQ-034 Macro IMEM_MISALIGN_TRAP_EN defined: a fetch with addr[1:0]!=0 returns NOOP with fault=1, and a loader handshake with ld_addr[1:0]!=0 is dropped and sets ld_err.
REQ-035 IMEM_MISALIGN_TRAP_EN undefined: addr[1:0] and ld_addr[1:0] are ignored, and misalignment never sets fault or ld_err.

Verification
REQ-036 Reset, then fetch 0x0 -> the next cycle gives instr=FC000000, valid=1, fault=0.
REQ-037 load_mode=1; load 0x0<-20100007 and 0x4<-AC100001; load_mode=0; wait 1 DRAIN cycle; fetch 0x0 and 0x4 -> the next cycles give 20100007 then AC100001, fault=0.
REQ-038 DEPTH=64, fetch 0x100 -> NOOP, fault=1; a loader handshake to 0x100 -> ld_err=1, which persists until reset.
REQ-039 Fetch 0x4 (loaded), then stall=1 for 3 cycles while addr changes to 0x0 -> instr stays AC100001 and valid stays 1.
REQ-040 Fetch during the LOAD and DRAIN cycles -> NOOP, fault=1; reset asserted mid-LOAD -> a later fetch of 0x0 returns NOOP and ld_ready=0.
REQ-041 Fetch 0x2 -> with IMEM_MISALIGN_TRAP_EN: NOOP, fault=1; without it: the word at 0x0, fault=0.
